// File: rtl/calc_seq_ctrl_if.sv
// Request/response bundle for calc_seq_ctrl: request handshake with operands,
// result handshake with qualifier flag, and a busy indicator.
interface calc_seq_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, funct, a, b, out_ready,
    input  in_ready, out_valid, result, div_by_zero, busy
  );

  modport slave (
    input  in_valid, funct, a, b, out_ready,
    output in_ready, out_valid, result, div_by_zero, busy
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Sequential calculator: single-cycle add/sub, iterative shift-add multiply and
// restoring divide, with an accumulator-style "prev" operand and a held result.
module calc_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  calc_seq_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] opa_q;   // multiplicand (shifts left) or dividend/quotient
  logic [WIDTH-1:0] opb_q;   // multiplier (shifts right) or divisor
  logic [WIDTH-1:0] acc_q;   // partial product or partial remainder
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] addsub_d;
  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             last_iter;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    op_a      = (bus.funct[2] ^ bus.funct[1]) ? prev_q : bus.a;
    addsub_d  = bus.funct[0] ? (op_a - bus.b) : (op_a + bus.b);
    mul_acc_d = acc_q + (opb_q[0] ? opa_q : '0);
    rem_sh    = {acc_q, opa_q[WIDTH-1]};
    rem_ge    = (rem_sh >= {1'b0, opb_q});
    rem_d     = rem_ge ? WIDTH'(rem_sh - {1'b0, opb_q}) : rem_sh[WIDTH-1:0];
    quo_d     = {opa_q[WIDTH-2:0], rem_ge};
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (!bus.funct[1]) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= addsub_d;
              prev_q      <= addsub_d;
              dbz_q       <= 1'b0;
            end else if (bus.funct[0] && (bus.b == '0)) begin
              // Divide by zero completes at once and leaves prev untouched.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= '1;
              dbz_q       <= 1'b1;
            end else begin
              state_q  <= CALC;
              busy_q   <= 1'b1;
              opa_q    <= op_a;
              opb_q    <= bus.b;
              acc_q    <= '0;
              cnt_q    <= '0;
              is_div_q <= bus.funct[0];
            end
          end
        end

        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            acc_q <= rem_d;
            opa_q <= quo_d;
          end else begin
            acc_q <= mul_acc_d;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
          end
          if (last_iter) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            dbz_q       <= 1'b0;
            result_q    <= is_div_q ? quo_d : mul_acc_d;
            prev_q      <= is_div_q ? quo_d : mul_acc_d;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl (WIDTH=8): a reference model pushes the
// expected result, flag and latency at each request; they are popped at output.
module tb_calc_seq_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  calc_seq_ctrl_if #(.WIDTH(W)) bus ();

  calc_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t         sb_q[$];
  logic [W-1:0] prev_m;
  int           n_pass = 0;
  int           n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] x;
    logic [2*W-1:0] prod;
    x     = (f[2] ^ f[1]) ? prev_m : a;
    e.dbz = 1'b0;
    e.lat = 1;
    case (f[1:0])
      2'b00: e.res = x + b;
      2'b01: e.res = x - b;
      2'b10: begin prod = x * b; e.res = prod[W-1:0]; e.lat = W + 1; end
      default: begin
        if (b == 0) begin e.res = '1; e.dbz = 1'b1; end
        else begin e.res = x / b; e.lat = W + 1; end
      end
    endcase
    if (!e.dbz) prev_m = e.res;
    return e;
  endfunction

  // Issue one request, scramble inputs after accept, then wait for and score the result.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   lat;
    int   busy_cnt;
    @(negedge clk);
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.funct    = f;
    bus.a        = a;
    bus.b        = b;
    sb_q.push_back(model(f, a, b));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.funct    = 3'($urandom);
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    lat      = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) break;
      if (lat > 100) begin
        chk({tag, ".timeout"}, 0, 1);
        break;
      end
    end
    e = sb_q.pop_front();
    chk({tag, ".result"}, bus.result, e.res);
    chk({tag, ".dbz"}, bus.div_by_zero, e.dbz);
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".busy_cycles"}, busy_cnt, e.lat - 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, bus.out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] held;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.funct     = '0;
    bus.a         = '0;
    bus.b         = '0;
    prev_m        = '0;
    #12;
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.result", bus.result, 0);
    chk("rst.dbz", bus.div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", bus.in_ready, 1);

    do_op("add",      3'b000, 8'd200, 8'd100);  // 44
    do_op("sub_prev", 3'b101, 8'd0,   8'd50);   // 250
    do_op("mul_prev", 3'b010, 8'd0,   8'd2);    // 244
    do_op("mul",      3'b110, 8'd13,  8'd11);   // 143
    do_op("div",      3'b111, 8'd100, 8'd7);    // 14
    do_op("div0",     3'b011, 8'd0,   8'd0);    // 255, flag
    do_op("add_prev", 3'b100, 8'd0,   8'd1);    // 15 (prev kept at 14)

    // Stall in DONE with new requests presented and operands moving.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct    = 3'b000;
    bus.a        = 8'd5;
    bus.b        = 8'd6;
    sb_q.push_back(model(3'b000, 8'd5, 8'd6));
    @(negedge clk);
    chk("stall.out_valid", bus.out_valid, 1);
    held = bus.result;
    chk("stall.result", held, sb_q[0].res);
    for (int i = 0; i < 5; i++) begin
      bus.a = W'(i * 37 + 1);
      @(negedge clk);
      chk("stall.hold_result", bus.result, held);
      chk("stall.hold_valid", bus.out_valid, 1);
      chk("stall.in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    void'(sb_q.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall.no_extra", bus.out_valid, 0);
    end
    do_op("after_stall", 3'b100, 8'd0, 8'd4);   // 15

    // Reset while the multiplier is mid-iteration.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct    = 3'b110;
    bus.a        = 8'd13;
    bus.b        = 8'd11;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort.result", bus.result, 0);
    chk("abort.out_valid", bus.out_valid, 0);
    chk("abort.busy", bus.busy, 0);
    chk("abort.dbz", bus.div_by_zero, 0);
    prev_m = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort.in_ready", bus.in_ready, 1);
    chk("abort.no_result", bus.out_valid, 0);
    do_op("post_abort", 3'b100, 8'd0, 8'd3);    // 3

    for (int i = 0; i < 8; i++) begin
      logic [2:0] f;
      f = 3'($urandom);
      do_op($sformatf("rnd%0d", i), f, W'($urandom), W'($urandom_range(0, 20)));
    end

    chk("sb.empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port funct  input  3  opcode.
REQ-007 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  second operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port div_by_zero  output  1  flag qualifying result.
REQ-013 SHALL have port busy  output  1  high in CALC state.

Function
REQ-014 SHALL decode funct: 000 a+b; 001 a-b; 110 a*b; 111 a/b; 100 prev+b; 101 prev-b; 010 prev*b; 011 prev/b; prev = internal WIDTH-bit register.
REQ-015 SHALL wrap add/sub results modulo 2^WIDTH; multiply keeps low WIDTH bits of product; divide is unsigned quotient, truncated.
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE, busy=1 only in CALC.
REQ-017 SHALL accept a request on the edge where in_valid&&in_ready, latching funct, operand A (a or prev) and b.
REQ-018 SHALL, for add/sub, go IDLE->DONE on the accept edge; result valid 1 cycle after accept.
REQ-019 SHALL, for mult (shift-add) and div (restoring), go IDLE->CALC, perform one iteration per cycle using an iteration counter 0..WIDTH-1, and enter DONE on the edge completing iteration WIDTH-1; out_valid first high WIDTH+1 cycles after accept edge.
REQ-020 SHALL, for div/prev-div with divisor 0, go IDLE->DONE directly (1-cycle latency) with result all ones and div_by_zero=1; prev SHALL be unchanged.
REQ-021 SHALL clear div_by_zero for every other completed operation.
REQ-022 SHALL load prev with result on DONE entry for all non-divide-by-zero operations.
REQ-023 SHALL hold result, div_by_zero and out_valid stable in DONE while out_ready=0 (unbounded stall).
REQ-024 SHALL return DONE->IDLE on the edge where out_valid&&out_ready; in_ready rises the following cycle (no accept in same cycle as output handshake).
REQ-025 SHALL ignore in_valid, funct, a, b while not in IDLE; operands latched at accept SHALL be used regardless of later input changes.
REQ-026 SHALL ignore out_ready outside DONE.

Reset
REQ-027 SHALL, while reset=1 (asynchronously, mid-operation included), force state IDLE, prev=0, result=0, counter=0, out_valid=0, div_by_zero=0, busy=0; in_ready=1 after reset deasserts.
REQ-028 SHALL abort any in-progress CALC on reset with no result produced.

Verification (WIDTH=8)
REQ-029 SHALL verify: ADD a=200 b=100 -> result=44, out_valid 1 cycle after accept, prev=44.
REQ-030 SHALL verify: then SUBToPrev b=50 -> result=250; then MULTWithPrev b=2 -> result=244 after 9 cycles.
REQ-031 SHALL verify: MULT a=13 b=11 -> busy high 8 cycles, result=143; DIV a=100 b=7 -> result=14.
REQ-032 SHALL verify: DIVByPrev b=0 with prev=14 -> result=255, div_by_zero=1, 1-cycle latency; next ADDToPrev b=1 -> result=15, div_by_zero=0.
REQ-033 SHALL verify: out_ready held 0 for 5 cycles in DONE with in_valid=1 and changing a -> result stable, in_ready=0, no new accept.
REQ-034 SHALL verify: reset pulse at iteration 4 of MULT -> all outputs 0 immediately, in_ready=1 after release, next ADDToPrev b=3 -> result=3.
